// File: rtl/lpc_pkg.sv
// Shared LPC datapath definitions.
// Register-file geometry and word type.
package lpc_pkg;

   localparam int REG_WIDTH = 16;
   localparam int REG_DEPTH = 160;
   localparam int REG_AW    = 8;

   typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_16x160_if.sv
// Write/read port bundle for the LPC register file.
// master drives address/data, slave returns read data.
interface reg_file_16x160_if
   import lpc_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int AW    = REG_AW
);

   logic             wen;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;

   modport master (
      output wen,
      output waddr,
      output raddr,
      output din,
      input  dout
   );

   modport slave (
      input  wen,
      input  waddr,
      input  raddr,
      input  din,
      output dout
   );

endinterface

// File: rtl/reg_word_cell.sv
// One storage word: async active-low clear, load enable.
module reg_word_cell #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_file_16x160.sv
// 160x16 register file: sync write, combinational read.
// Out-of-range addresses never decode, so writes drop and reads give 0.
module reg_file_16x160
   import lpc_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_DEPTH,
   parameter int AW    = REG_AW
) (
   input logic               clk,
   input logic               reset,
   reg_file_16x160_if.slave  bus
);

   logic [DEPTH-1:0] w_wsel;
   logic [WIDTH-1:0] w_q [DEPTH];
   logic [WIDTH-1:0] w_rdata;

   // One-hot decode; addresses >= DEPTH match no entry.
   always_comb begin
      w_wsel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_wsel[i] = bus.wen && (bus.waddr == AW'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      reg_word_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .clk    (clk),
         .rst_n  (reset),
         .i_load (w_wsel[g]),
         .i_d    (bus.din),
         .o_q    (w_q[g])
      );
   end

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.raddr == AW'(i)) begin
            w_rdata = w_q[i];
         end
      end
   end

   assign bus.dout = w_rdata;

endmodule

// File: tb/tb_reg_file_16x160.sv
// Bench for reg_file_16x160: vector table, scoreboard queue,
// plus hand sequences for reset and same-address timing.
module tb_reg_file_16x160;
   import lpc_pkg::*;

   typedef struct {
      string       name;
      logic        wen;
      logic [7:0]  waddr;
      logic [15:0] din;
      logic [7:0]  raddr;
      logic [15:0] exp;
   } vec_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   logic [15:0] mdl [160];
   logic [15:0] exp_q [$];
   vec_t        tbl [$];

   reg_file_16x160_if #(.WIDTH(16), .AW(8)) bus ();

   reg_file_16x160 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [15:0] exp);
      tests++;
      if (bus.dout !== exp) begin
         fails++;
         $display("FAIL %s: dout=%h expected %h", nm, bus.dout, exp);
      end
   endtask

   task automatic pop_check(input string nm);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         check(nm, e);
      end
   endtask

   // Drive at negedge, clock it in, compare 1ns after the edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      bus.wen   = v.wen;
      bus.waddr = v.waddr;
      bus.din   = v.din;
      bus.raddr = v.raddr;
      exp_q.push_back(v.exp);
      if (v.wen && v.waddr < 8'd160) mdl[v.waddr] = v.din;
      @(posedge clk);
      #1;
      pop_check(v.name);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      vec_t v;
      v = '{"wr", 1'b1, a, d, a, (a < 8'd160) ? d : 16'h0000};
      apply(v);
   endtask

   task automatic rd(input string nm, input logic [7:0] a,
                     input logic [15:0] e);
      bus.raddr = a;
      exp_q.push_back(e);
      #1;
      pop_check(nm);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 160; i++) mdl[i] = 16'h0000;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      clear_model();
      bus.wen   = 1'b0;
      bus.waddr = '0;
      bus.din   = '0;
      bus.raddr = '0;
      reset     = 1'b0;

      // Reset state, with a write attempted while held.
      bus.wen   = 1'b1;
      bus.waddr = 8'd3;
      bus.din   = 16'h5555;
      repeat (2) @(posedge clk);
      #1;
      bus.wen = 1'b0;
      rd("reset_rd0", 8'd0, 16'h0000);
      rd("reset_blocks_wr", 8'd3, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Reset clear
      wr(8'd0, 16'hFFFF);
      wr(8'd80, 16'hFFFF);
      wr(8'd159, 16'hFFFF);
      @(negedge clk);
      bus.wen = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      clear_model();
      rd("clr_0", 8'd0, 16'h0000);
      rd("clr_80", 8'd80, 16'h0000);
      rd("clr_159", 8'd159, 16'h0000);

      tbl.push_back('{"ow_1234",  1'b1, 8'd0,   16'h1234, 8'd0,   16'h1234});
      tbl.push_back('{"ow_5678",  1'b1, 8'd0,   16'h5678, 8'd0,   16'h5678});
      tbl.push_back('{"wr9_rd0",  1'b1, 8'd9,   16'hABCD, 8'd0,   16'h5678});
      tbl.push_back('{"rd9",      1'b0, 8'd9,   16'h0000, 8'd9,   16'hABCD});
      tbl.push_back('{"rd0",      1'b0, 8'd0,   16'h0000, 8'd0,   16'h5678});
      tbl.push_back('{"wr159",    1'b1, 8'd159, 16'h00C5, 8'd159, 16'h00C5});
      tbl.push_back('{"wr200",    1'b1, 8'd200, 16'hDEAD, 8'd200, 16'h0000});
      tbl.push_back('{"no_alias", 1'b0, 8'd0,   16'h0000, 8'd40,  16'h0000});
      tbl.push_back('{"rd159",    1'b0, 8'd0,   16'h0000, 8'd159, 16'h00C5});
      tbl.push_back('{"wdis_a",   1'b0, 8'd5,   16'h1111, 8'd5,   16'h0000});
      tbl.push_back('{"wdis_b",   1'b0, 8'd5,   16'h1111, 8'd5,   16'h0000});
      tbl.push_back('{"wdis_c",   1'b0, 8'd5,   16'h1111, 8'd5,   16'h0000});
      tbl.push_back('{"wr255",    1'b1, 8'd255, 16'hFFFF, 8'd255, 16'h0000});
      tbl.push_back('{"wr160",    1'b1, 8'd160, 16'hBEEF, 8'd0,   16'h5678});
      tbl.push_back('{"rd160",    1'b0, 8'd0,   16'h0000, 8'd160, 16'h0000});
      foreach (tbl[i]) apply(tbl[i]);

      // Full sweep against the model after out-of-range writes.
      @(negedge clk);
      for (int i = 0; i < 160; i++) begin
         rd($sformatf("sweep_%0d", i), 8'(i), mdl[i]);
      end

      // Same-address read during write.
      wr(8'd7, 16'h0001);
      @(negedge clk);
      bus.wen   = 1'b1;
      bus.waddr = 8'd7;
      bus.raddr = 8'd7;
      bus.din   = 16'h0002;
      #1;
      check("rw_before", 16'h0001);
      @(posedge clk);
      #1;
      check("rw_after", 16'h0002);

      // Async reset between edges with a write pending.
      @(negedge clk);
      bus.din = 16'h0003;
      #2;
      reset = 1'b0;
      #1;
      check("async_rst", 16'h0000);
      @(posedge clk);
      #1;
      check("rst_wr_blocked", 16'h0000);
      @(negedge clk);
      bus.wen = 1'b0;
      reset   = 1'b1;
      #1;
      check("after_rst", 16'h0000);
      rd("after_rst_9", 8'd9, 16'h0000);

      // First edge after deassertion writes.
      wr(8'd12, 16'h0C0C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_file_16x160.md
# reg_file_16x160

Single-port-write, single-port-read register file holding 160 words of 16 bits, used as the coefficient/sample store in the LPC datapath. Writes are synchronous to `clk`. Reads are combinational from the addressed entry. An asynchronous active-low reset clears all entries to zero. Addresses outside 0–159 are safely ignored on write and return zero on read.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 160, number of storage entries
- `AW`, 8, address width; must satisfy 2^AW ≥ DEPTH

Ports:
- `clk`  in  1  clock; all writes occur on its rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 clears the array immediately, independent of `clk`)
- `wen`  in  1  write enable, active-high, sampled at rising `clk`
- `waddr`  in  AW  write address
- `raddr`  in  AW  read address
- `din`  in  WIDTH  write data
- `dout`  out  WIDTH  read data for `raddr`

## Operation
- Storage: DEPTH × WIDTH flip-flop array. Entries are indexed 0..DEPTH-1.
- Reset: while `reset`=0, every entry is 0 and writes are blocked. Consequently `dout`=0 for any `raddr`.
- Write: at a rising `clk` with `reset`=1, `wen`=1 and `waddr` < DEPTH, `mem[waddr]` takes `din`. No other entry changes.
- `wen`=0: no entry changes.
- `waddr` ≥ DEPTH (160–255): the write is dropped silently. No entry changes and there is no aliasing or wrap-around.
- Read: `dout` = `mem[raddr]` when `raddr` < DEPTH, otherwise 0. The read path is purely combinational with no enable.
- Successive writes to the same address: the last write wins.
- There is no write-to-read bypass.

## Timing
- Write latency: the new value is visible on `dout` (if `raddr`=`waddr`) immediately after the rising edge that performs the write, within the same cycle.
- Read latency: zero cycles. `dout` follows `raddr` and array contents combinationally.
- Same-address read during write: `dout` shows the old value before the edge and `din` after the edge.
- Reset assertion is asynchronous. The array is cleared without a clock edge, and `dout`=0 as soon as reset propagates.
- Reset deassertion: the first write can occur at the first rising edge after `reset` goes high. Deassertion is assumed to meet recovery timing; there is no internal synchronizer.
- Reset asserted mid-write: reset has priority, and the entry ends at 0.

## Structure
- Shared package `lpc_pkg`:
  - `REG_WIDTH`=16
  - `REG_DEPTH`=160
  - `REG_AW`=8
  - typedef `reg_word_t` (16-bit logic)
- The top module instantiates DEPTH copies of sub-module `reg_word_cell`. Each copy is one WIDTH-bit register with async active-low clear and a load enable.
- The top module contains:
  - the write-address decoder (one-hot, gated by `wen` and the range check)
  - the read multiplexer with out-of-range zeroing

## Test plan
- Reset clear: write 0xFFFF to addresses 0, 80 and 159, then pulse `reset`=0 for 1 cycle → reads of 0, 80 and 159 all give 0x0000.
- Overwrite and readback: `wen`=1, `waddr`=0, `din`=0x1234 for one edge; then `din`=0x5678 for one edge; then `waddr`=9, `din`=0xABCD for one edge; then `wen`=0 → `raddr`=0 gives 0x5678 and `raddr`=9 gives 0xABCD.
- Boundary and out-of-range:
  - write 0x00C5 to address 159 → read 159 gives 0x00C5
  - write 0xDEAD to address 200 → read 200 gives 0x0000, and reads of 0..159 are unchanged (no alias at 200−160=40)
- Write disable: `wen`=0, `waddr`=5, `din`=0x1111 over several edges → read 5 keeps its prior value (0x0000 after reset).
- Read/write same address: `raddr`=`waddr`=7, entry holds 0x0001, drive `din`=0x0002 with `wen`=1 → `dout`=0x0001 before the edge and 0x0002 after it.
- Async reset mid-stream: assert `reset`=0 between clock edges while `wen`=1 → `dout` goes to 0 before the next edge, and the pending write has no effect.
